// File: rtl/neuron_2input_backprop_pkg.sv
// neuron_2input_backprop_pkg: shared width, latency and FSM state encoding
package neuron_2input_backprop_pkg;
    localparam int W = 32;
    localparam int LAT = 9;
    typedef enum logic [3:0] {IDLE, S0, S1, S2, S3, S4, S5, S6, UPD, DONE} state_t;
endpackage

// File: rtl/neuron_2input_backprop_mul_32s_trunc.sv
// mul_32s_trunc: combinational signed multiply keeping the low word of the product
module mul_32s_trunc
    import neuron_2input_backprop_pkg::*;
(
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] p
);
    assign p = a * b;
endmodule

// File: rtl/neuron_2input_backprop.sv
// neuron_2input_backprop: sequential ReLU neuron backward pass with SGD update over one shared multiplier
module neuron_2input_backprop
    import neuron_2input_backprop_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [W-1:0] x1,
    input  logic signed [W-1:0] x2,
    input  logic signed [W-1:0] w1,
    input  logic signed [W-1:0] w2,
    input  logic signed [W-1:0] b,
    input  logic signed [W-1:0] grad_out,
    input  logic        [4:0]   lr_shift,
    output logic                busy,
    output logic                done,
    output logic signed [W-1:0] w1_new,
    output logic signed [W-1:0] w2_new,
    output logic signed [W-1:0] b_new,
    output logic signed [W-1:0] grad_x1,
    output logic signed [W-1:0] grad_x2
);
    state_t state;
    logic signed [W-1:0] rx1, rx2, rw1, rw2, rb, rg, z, zb, delta, dw1, dw2, gx1, gx2, ma, mb, p;
    logic [4:0] lr;
    always_comb begin
        ma = (state == S0) ? rw1 : (state == S1) ? rw2 : delta;
        mb = (state == S0 || state == S3) ? rx1 :
             (state == S1 || state == S4) ? rx2 :
             (state == S5) ? rw1 : rw2;
        zb = z + rb;
    end
    mul_32s_trunc u_mul (.a(ma), .b(mb), .p(p));
    // gradients are staged internally so the visible outputs only change on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            w1_new <= '0;
            w2_new <= '0;
            b_new <= '0;
            grad_x1 <= '0;
            grad_x2 <= '0;
        end else begin
            done <= state == UPD;
            busy <= (state == IDLE) ? start : state != DONE;
            case (state)
                IDLE: if (start) begin
                    rx1 <= x1;
                    rx2 <= x2;
                    rw1 <= w1;
                    rw2 <= w2;
                    rb <= b;
                    rg <= grad_out;
                    lr <= lr_shift;
                    state <= S0;
                end
                S0: begin z <= p; state <= S1; end
                S1: begin z <= z + p; state <= S2; end
                S2: begin delta <= (zb > 0) ? rg : '0; state <= S3; end
                S3: begin dw1 <= p; state <= S4; end
                S4: begin dw2 <= p; state <= S5; end
                S5: begin gx1 <= p; state <= S6; end
                S6: begin gx2 <= p; state <= UPD; end
                UPD: begin
                    w1_new <= rw1 - (dw1 >>> lr);
                    w2_new <= rw2 - (dw2 >>> lr);
                    b_new <= rb - (delta >>> lr);
                    grad_x1 <= gx1;
                    grad_x2 <= gx2;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_2input_backprop.sv
// tb_neuron_2input_backprop: directed vectors, expected results queued and checked by a done-driven monitor
module tb_neuron_2input_backprop;
    typedef struct packed {
        logic [31:0] w1n, w2n, bn, gx1, gx2;
    } exp_t;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic signed [31:0] x1 = '0, x2 = '0, w1 = '0, w2 = '0, b = '0, grad_out = '0;
    logic [4:0] lr_shift = '0;
    logic busy, done;
    logic signed [31:0] w1_new, w2_new, b_new, grad_x1, grad_x2;
    exp_t sb[$];
    exp_t me;
    int checks = 0, errors = 0;
    neuron_2input_backprop dut (
        .clk(clk), .rst(rst), .start(start), .x1(x1), .x2(x2), .w1(w1), .w2(w2), .b(b),
        .grad_out(grad_out), .lr_shift(lr_shift), .busy(busy), .done(done),
        .w1_new(w1_new), .w2_new(w2_new), .b_new(b_new), .grad_x1(grad_x1), .grad_x2(grad_x2)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", n, $signed(a), $signed(e));
        end
    endtask
    function automatic exp_t mk(input int a, input int c, input int d, input int f, input int g);
        mk.w1n = a; mk.w2n = c; mk.bn = d; mk.gx1 = f; mk.gx2 = g;
    endfunction
    always @(negedge clk) if (done) begin
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done got done=1 expected done=0");
        end else begin
            me = sb.pop_front();
            chk("w1_new", w1_new, me.w1n);
            chk("w2_new", w2_new, me.w2n);
            chk("b_new", b_new, me.bn);
            chk("grad_x1", grad_x1, me.gx1);
            chk("grad_x2", grad_x2, me.gx2);
        end
    end
    task automatic drive(input int a1, input int a2, input int v1, input int v2, input int vb, input int g, input int sh);
        x1 = a1; x2 = a2; w1 = v1; w2 = v2; b = vb; grad_out = g; lr_shift = 5'(sh);
    endtask
    task automatic scramble();
        drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    endtask
    task automatic run_pass(input int a1, input int a2, input int v1, input int v2, input int vb, input int g, input int sh, input exp_t e);
        int n = 0;
        @(negedge clk);
        drive(a1, a2, v1, v2, vb, g, sh);
        start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        scramble();
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got done=0 expected done=1");
        end
        @(negedge clk);
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_w1_new"}, w1_new, 32'd0);
        chk({tag, "_w2_new"}, w2_new, 32'd0);
        chk({tag, "_b_new"}, b_new, 32'd0);
        chk({tag, "_grad_x1"}, grad_x1, 32'd0);
        chk({tag, "_grad_x2"}, grad_x2, 32'd0);
    endtask
    initial begin
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        run_pass(3, -2, 4, 5, 1, 8, 1, mk(-8, 13, -3, 32, 40));
        run_pass(1, 1, -3, 1, 2, 100, 1, mk(-3, 1, 2, 0, 0));
        run_pass(32'h10000, 0, 32'h10000, 0, 0, 5, 3, mk(32'h10000, 0, 0, 0, 0));
        run_pass(3, -2, 4, 5, 1, 8, 0, mk(-20, 21, -7, 32, 40));
        run_pass(3, -2, 4, 5, 1, 8, 31, mk(4, 6, 1, 32, 40));
        run_pass(2, 3, 1, 1, 0, -6, 2, mk(4, 6, 2, -6, -6));
        run_pass(1, 0, -5, 0, 0, 7, 0, mk(-5, 0, 0, 0, 0));
        run_pass(1, 0, 32'h7fffffff, 0, 1, 3, 0, mk(32'h7fffffff, 0, 1, 0, 0));
        // latency: busy for 9 cycles, done only in the 9th, starts at cycles 3 and 9 ignored
        @(negedge clk);
        drive(3, -2, 4, 5, 1, 8, 1);
        start = 1'b1;
        sb.push_back(mk(-8, 13, -3, 32, 40));
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            start = (k == 3 || k == 9);
            chk($sformatf("lat_busy_c%0d", k), 32'(busy), 32'(k <= 9));
            chk($sformatf("lat_done_c%0d", k), 32'(done), 32'(k == 9));
        end
        // reset asserted while the pass sits in S4
        @(negedge clk);
        drive(2, 3, 1, 1, 0, -6, 2);
        start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk_zero("abort");
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_idle_busy", 32'(busy), 32'd0);
        run_pass(3, -2, 4, 5, 1, 8, 1, mk(-8, 13, -3, 32, 40));
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/neuron_2input_backprop.md
NEURON_2INPUT_BACKPROP -- requirements
Module: neuron_2input_backprop

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock); rst input 1 (synchronous, active-high reset).
REQ-002 The module SHALL have input start, 1 bit: pulse that requests one backward pass; sampled only in IDLE.
REQ-003 The module SHALL have inputs x1, x2, w1, w2, b, each 32 bits, signed two's complement: forward-pass operands.
REQ-004 The module SHALL have input grad_out, 32 bits, signed: upstream gradient dL/df.
REQ-005 The module SHALL have input lr_shift, 5 bits, unsigned: learning rate expressed as 2^-lr_shift.
REQ-006 The module SHALL have output busy, 1 bit: high in every state except IDLE.
REQ-007 The module SHALL have output done, 1 bit: one-cycle pulse when the results are valid.
REQ-008 The module SHALL have outputs w1_new, w2_new and b_new, each 32 bits, signed: updated parameters.
REQ-009 The module SHALL have outputs grad_x1 and grad_x2, each 32 bits, signed: gradients passed to the previous layer.

Function
REQ-010 In IDLE with start=1, the module SHALL capture x1, x2, w1, w2, b, grad_out and lr_shift into internal registers on that edge; later input changes SHALL NOT affect the pass in progress.
REQ-011 The FSM SHALL have these states: IDLE, S0 to S6, UPD and DONE. Transitions: IDLE to S0 on start; S0 to S6 in order, one cycle each; S6 to UPD; UPD to DONE; DONE to IDLE unconditionally.
REQ-012 A single shared 32x32 signed multiplier SHALL be used, keeping only the low 32 bits of each product.
REQ-013 The steps SHALL compute the following:
- S0: z = w1*x1.
- S1: z += w2*x2.
- S2: z += b; delta = (z > 0) ? grad_out : 0 (ReLU derivative; z = 0 gives 0).
- S3: dw1 = delta*x1.
- S4: dw2 = delta*x2.
- S5: grad_x1 = delta*w1.
- S6: grad_x2 = delta*w2.
REQ-014 UPD SHALL compute:
- w1_new = w1 - (dw1 >>> lr_shift).
- w2_new = w2 - (dw2 >>> lr_shift).
- b_new = b - (delta >>> lr_shift).
The shift is arithmetic; all sums SHALL wrap modulo 2^32 with no saturation.
REQ-015 done SHALL be high in the DONE state only; it rises exactly 9 clock cycles after the edge that captured start.
REQ-016 The result outputs SHALL be registered, SHALL update no later than the DONE cycle, and SHALL hold their values until the next pass reaches DONE.
REQ-017 start SHALL be ignored while busy=1, including during the DONE cycle.
REQ-018 With lr_shift=0 the full gradient SHALL be applied; with lr_shift=31 each correction SHALL be 0 or -1.

Reset
REQ-019 When rst=1 at a clock edge, the module SHALL go to IDLE, and busy, done and all result outputs SHALL become 0.
REQ-020 Reset SHALL take priority over start and over any pass in progress; an aborted pass SHALL NOT produce done.
REQ-021 After reset is released, the first start SHALL be accepted on the first edge at which it is high.

Structure
REQ-022 A shared package SHALL hold the data width constant (32), the FSM state enumeration and the latency constant (9).
REQ-023 The shared multiplier SHALL be one sub-module, mul_32s_trunc, which computes the low 32 bits of a signed product combinationally.
REQ-024 The FSM, step sequencing and update arithmetic SHALL stay in the top module.

Verification
REQ-025 Active neuron: x1=3, x2=-2, w1=4, w2=5, b=1, grad_out=8, lr_shift=1 -> z=3, and at done: grad_x1=32, grad_x2=40, w1_new=-8, w2_new=13, b_new=-3.
REQ-026 Boundary z=0: x1=1, x2=1, w1=-3, w2=1, b=2, grad_out=100 -> grad_x1=0, grad_x2=0, w1_new=-3, w2_new=1, b_new=2.
REQ-027 Product wrap: w1=x1=0x00010000, w2=x2=0, b=0, grad_out=5 -> product wraps to 0, z=0, neuron inactive, parameters unchanged.
REQ-028 Latency and busy: a single start pulse -> busy=1 for 9 cycles and done high only in cycle 9; a second start issued at cycles 3 and 9 -> ignored, with exactly one done.
REQ-029 Reset mid-pass: assert rst in S4 -> the next edge gives IDLE with all outputs 0, no done follows, and a new start afterward completes correctly.
